// File: rtl/combo_dialer_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : combo_dialer_pkg
//  Purpose  : Shared definitions for the combo dialer: FSM state encodings,
//             dial direction constants, button selects and the 4-bit
//             shortest-path helper (also usable by lock display logic).
//  Revision : 1.0  initial release
// ============================================================================
package combo_dialer_pkg;

    // FSM state encodings
    localparam logic [2:0] c_ST_IDLE    = 3'd0;
    localparam logic [2:0] c_ST_LOAD    = 3'd1;
    localparam logic [2:0] c_ST_STEP_HI = 3'd2;
    localparam logic [2:0] c_ST_STEP_LO = 3'd3;
    localparam logic [2:0] c_ST_CONF_HI = 3'd4;
    localparam logic [2:0] c_ST_CONF_LO = 3'd5;
    localparam logic [2:0] c_ST_DONE    = 3'd6;

    // Dial directions: L decrements, R increments the lock's dial
    localparam logic c_DIR_L = 1'b0;
    localparam logic c_DIR_R = 1'b1;

    // Which button the shared pulse generator is routed to
    localparam logic [1:0] c_SEL_L = 2'd0;
    localparam logic [1:0] c_SEL_R = 2'd1;
    localparam logic [1:0] c_SEL_C = 2'd2;

    typedef struct packed {
        logic       dir;
        logic [3:0] steps;
    } path_t;

    // Shortest way round a 16-position dial. diff = (target - current) mod 16.
    // Half-way (8) resolves to R; diff = 0 yields zero steps.
    function automatic path_t shortest_path(input logic [3:0] diff);
        path_t p;
        if (diff <= 4'd8) begin
            p.dir   = c_DIR_R;
            p.steps = diff;
        end else begin
            p.dir   = c_DIR_L;
            p.steps = 4'd0 - diff;
        end
        return p;
    endfunction

endpackage : combo_dialer_pkg
`default_nettype wire

// File: rtl/combo_pulse_gen.sv
`default_nettype none
// ============================================================================
//  Module   : combo_pulse_gen
//  Purpose  : On a go strobe, drives o_pulse high for PULSE_CYC cycles, then
//             low for GAP_CYC cycles. Flags the last high cycle and the last
//             gap cycle so the caller can chain the next pulse with no slack.
//  Revision : 1.0  initial release
// ============================================================================
module combo_pulse_gen #(
    parameter int PULSE_CYC = 1,
    parameter int GAP_CYC   = 3,
    parameter int CNT_W     = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic i_go,
    output logic o_pulse,
    output logic o_hi_last,
    output logic o_last
);

    localparam logic [CNT_W-1:0] c_PULSE_LAST = CNT_W'(PULSE_CYC - 1);
    localparam logic [CNT_W-1:0] c_GAP_LAST   = CNT_W'(GAP_CYC - 1);

    logic             r_active;
    logic             r_pulse;
    logic [CNT_W-1:0] r_cnt;

    // Phase timer: a go restarts the high phase even on the final gap cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            r_active <= 1'b0;
            r_pulse  <= 1'b0;
            r_cnt    <= '0;
        end else if (i_go) begin
            r_active <= 1'b1;
            r_pulse  <= 1'b1;
            r_cnt    <= c_PULSE_LAST;
        end else if (r_active) begin
            if (r_cnt != '0) begin
                r_cnt <= r_cnt - 1'b1;
            end else if (r_pulse) begin
                r_pulse <= 1'b0;
                r_cnt   <= c_GAP_LAST;
            end else begin
                r_active <= 1'b0;
            end
        end
    end

    assign o_pulse   = r_pulse;
    assign o_hi_last = r_active &  r_pulse & (r_cnt == '0);
    assign o_last    = r_active & ~r_pulse & (r_cnt == '0);

endmodule : combo_pulse_gen
`default_nettype wire

// File: rtl/combo_dialer.sv
`default_nettype none
// ============================================================================
//  Module   : combo_dialer
//  Purpose  : Button-side stimulus generator for the combo lock. Dials each
//             hex digit of i_code (MS digit first) the shortest way round
//             using btn_l / btn_r pulses, then confirms with btn_c.
//  Revision : 1.0  initial release
// ============================================================================
module combo_dialer
    import combo_dialer_pkg::*;
#(
    parameter int NUM_DIGITS = 4,
    parameter int PULSE_CYC  = 1,
    parameter int GAP_CYC    = 3,
    parameter int CNT_W      = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    i_start,
    input  logic [4*NUM_DIGITS-1:0] i_code,
    input  logic                    i_pos_sync,
    output logic                    o_btn_l,
    output logic                    o_btn_r,
    output logic                    o_btn_c,
    output logic                    o_busy,
    output logic                    o_done,
    output logic [3:0]              o_dial_pos
);

    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    logic [2:0]              r_state;
    logic [2:0]              w_state_nxt;
    logic [4*NUM_DIGITS-1:0] r_code;
    logic [IDX_W-1:0]        r_idx;
    logic                    r_dir;
    logic [3:0]              r_steps;
    logic [1:0]              r_sel;
    logic [1:0]              w_sel_nxt;
    logic [3:0]              r_dial;
    logic                    r_busy;
    logic                    r_done;
    logic                    w_busy_nxt;
    logic                    w_done_nxt;
    logic                    w_go;
    logic                    w_pulse;
    logic                    w_hi_last;
    logic                    w_last;
    logic [3:0]              w_target;
    logic [3:0]              w_diff;
    path_t                   w_path;

    // Current digit and its shortest route from the modelled dial position
    assign w_target = r_code[{r_idx, 2'b00} +: 4];
    assign w_diff   = w_target - r_dial;
    assign w_path   = shortest_path(w_diff);

    // Shared pulse/gap timer for every button press
    combo_pulse_gen #(
        .PULSE_CYC (PULSE_CYC),
        .GAP_CYC   (GAP_CYC),
        .CNT_W     (CNT_W)
    ) u_pulse_gen (
        .clk       (clk),
        .rst       (rst),
        .i_go      (w_go),
        .o_pulse   (w_pulse),
        .o_hi_last (w_hi_last),
        .o_last    (w_last)
    );

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic; launches a pulse on every entry into a *_HI state
    always_comb begin
        w_state_nxt = r_state;
        w_go        = 1'b0;
        w_sel_nxt   = r_sel;
        case (r_state)
            c_ST_IDLE: begin
                if (i_start) begin
                    w_state_nxt = c_ST_LOAD;
                end
            end
            c_ST_LOAD: begin
                w_go = 1'b1;
                if (w_diff == 4'd0) begin
                    w_state_nxt = c_ST_CONF_HI;
                    w_sel_nxt   = c_SEL_C;
                end else begin
                    w_state_nxt = c_ST_STEP_HI;
                    w_sel_nxt   = (w_path.dir == c_DIR_R) ? c_SEL_R : c_SEL_L;
                end
            end
            c_ST_STEP_HI: begin
                if (w_hi_last) begin
                    w_state_nxt = c_ST_STEP_LO;
                end
            end
            c_ST_STEP_LO: begin
                if (w_last) begin
                    w_go = 1'b1;
                    if (r_steps > 4'd1) begin
                        w_state_nxt = c_ST_STEP_HI;
                    end else begin
                        w_state_nxt = c_ST_CONF_HI;
                        w_sel_nxt   = c_SEL_C;
                    end
                end
            end
            c_ST_CONF_HI: begin
                if (w_hi_last) begin
                    w_state_nxt = c_ST_CONF_LO;
                end
            end
            c_ST_CONF_LO: begin
                if (w_last) begin
                    w_state_nxt = (r_idx == '0) ? c_ST_DONE : c_ST_LOAD;
                end
            end
            c_ST_DONE: begin
                w_state_nxt = c_ST_IDLE;
            end
            default: begin
                w_state_nxt = c_ST_IDLE;
            end
        endcase
    end

    // Output decode from the next state so registered flags align with state
    always_comb begin
        w_busy_nxt = (w_state_nxt != c_ST_IDLE);
        w_done_nxt = (w_state_nxt == c_ST_DONE);
    end

    // Registered status outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            r_busy <= 1'b0;
            r_done <= 1'b0;
        end else begin
            r_busy <= w_busy_nxt;
            r_done <= w_done_nxt;
        end
    end

    // Sequence datapath: code latch, digit index, step count, button select
    always_ff @(posedge clk) begin
        if (rst) begin
            r_code  <= '0;
            r_idx   <= '0;
            r_dir   <= c_DIR_R;
            r_steps <= 4'd0;
            r_sel   <= c_SEL_C;
        end else begin
            r_sel <= w_sel_nxt;
            if (r_state == c_ST_IDLE && i_start) begin
                r_code <= i_code;
                r_idx  <= IDX_W'(NUM_DIGITS - 1);
            end
            if (r_state == c_ST_LOAD) begin
                r_dir   <= w_path.dir;
                r_steps <= w_path.steps;
            end
            if (r_state == c_ST_STEP_LO && w_last) begin
                r_steps <= r_steps - 4'd1;
            end
            if (r_state == c_ST_CONF_LO && w_last && r_idx != '0) begin
                r_idx <= r_idx - 1'b1;
            end
        end
    end

    // Dial model: pos_sync overrides a step landing on the same edge
    always_ff @(posedge clk) begin
        if (rst) begin
            r_dial <= 4'd0;
        end else if (i_pos_sync) begin
            r_dial <= 4'd0;
        end else if (r_state == c_ST_STEP_HI && w_hi_last) begin
            r_dial <= (r_dir == c_DIR_R) ? r_dial + 4'd1 : r_dial - 4'd1;
        end
    end

    // Route the single pulse source onto exactly one button
    assign o_btn_l    = w_pulse & (r_sel == c_SEL_L);
    assign o_btn_r    = w_pulse & (r_sel == c_SEL_R);
    assign o_btn_c    = w_pulse & (r_sel == c_SEL_C);
    assign o_busy     = r_busy;
    assign o_done     = r_done;
    assign o_dial_pos = r_dial;

endmodule : combo_dialer
`default_nettype wire
